// File: rtl/dsp19x2_pkg.sv
// Shared constants and types for the DSP19X2 dual accumulator.
// Holds product width, state enum and default frame/sum sizes.
package dsp19x2_pkg;

  localparam int PROD_W    = 19;
  localparam int DEF_LEN   = 16;
  localparam int DEF_ACC_W = 24;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/dsp19x2_dual_accumulator_if.sv
// Beat/result bus of the dual accumulator.
// master: z1/z2/in_valid/flush/out_ready out; slave: the block.
interface dsp19x2_dual_accumulator_if
  import dsp19x2_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = $clog2(DEF_LEN + 1)
) ();

  logic [PROD_W-1:0] z1;
  logic [PROD_W-1:0] z2;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [ACC_W-1:0]  sum1;
  logic [ACC_W-1:0]  sum2;
  logic [CNT_W-1:0]  count;
  logic [1:0]        ovf;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output z1, z2, in_valid, flush, out_ready,
    input  in_ready, sum1, sum2, count, ovf,
    input  out_valid
  );

  modport slave (
    input  z1, z2, in_valid, flush, out_ready,
    output in_ready, sum1, sum2, count, ovf,
    output out_valid
  );

endinterface

// File: rtl/dsp19x2_acc_lane.sv
// One accumulator lane: running sum plus sticky carry-out flag.
// Ports: i_clk, i_rst, i_add (beat), i_clr (frame end), i_z,
//   o_acc_nxt / o_ovf_nxt (values including the current beat).
// Macro DSP19X2_ACC_SAT_EN selects saturating add.
module dsp19x2_acc_lane
  import dsp19x2_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_add,
  input  logic              i_clr,
  input  logic [PROD_W-1:0] i_z,
  output logic [ACC_W-1:0]  o_acc_nxt,
  output logic              o_ovf_nxt
);

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_add_val;

  assign w_sum = {1'b0, r_acc}
               + {{(ACC_W + 1 - PROD_W){1'b0}}, i_z};
  assign w_carry = w_sum[ACC_W];

`ifdef DSP19X2_ACC_SAT_EN
  // Once clamped, any nonzero add carries again,
  // so the lane stays at max for the frame.
  assign w_add_val = w_carry ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_add_val = w_sum[ACC_W-1:0];
`endif

  assign o_acc_nxt = i_add ? w_add_val : r_acc;
  assign o_ovf_nxt = r_ovf | (i_add & w_carry);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= o_acc_nxt;
      r_ovf <= o_ovf_nxt;
    end
  end

endmodule

// File: rtl/dsp19x2_dual_accumulator.sv
// Frame accumulator behind the DSP19X2 dual 10x9 multiplier.
// Ports: i_clk, i_rst (async, active-high), io_bus (slave):
//   z1/z2/in_valid/in_ready/flush in, sum1/sum2/count/ovf/
//   out_valid/out_ready result handshake.
// Macro DSP19X2_ACC_SAT_EN: saturate lanes instead of wrap.
module dsp19x2_dual_accumulator
  import dsp19x2_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  dsp19x2_dual_accumulator_if.slave io_bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_in_ready;
  logic             w_beat;
  logic             w_end;
  logic             w_take;
  logic [ACC_W-1:0] w_acc1_nxt;
  logic [ACC_W-1:0] w_acc2_nxt;
  logic             w_ovf1_nxt;
  logic             w_ovf2_nxt;
  logic [ACC_W-1:0] r_sum1;
  logic [ACC_W-1:0] r_sum2;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_ovf;
  logic             r_out_valid;

  assign w_in_ready = (r_state == ACCUM);
  assign w_beat     = io_bus.in_valid & w_in_ready;
  assign w_cnt_nxt  = r_cnt + {{(CNT_W-1){1'b0}}, w_beat};
  assign w_take     = r_out_valid & io_bus.out_ready;

  // Flush only closes a frame that has at least one beat.
  assign w_end = w_in_ready
    & ((w_beat & (w_cnt_nxt == CNT_W'(LEN)))
    | (io_bus.flush & ((r_cnt != '0) | w_beat)));

  dsp19x2_acc_lane #(.ACC_W(ACC_W)) u_lane1 (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_add     (w_beat),
    .i_clr     (w_end),
    .i_z       (io_bus.z1),
    .o_acc_nxt (w_acc1_nxt),
    .o_ovf_nxt (w_ovf1_nxt)
  );

  dsp19x2_acc_lane #(.ACC_W(ACC_W)) u_lane2 (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_add     (w_beat),
    .i_clr     (w_end),
    .i_z       (io_bus.z2),
    .o_acc_nxt (w_acc2_nxt),
    .o_ovf_nxt (w_ovf2_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ACCUM: if (w_end)  w_state_nxt = HOLD;
      HOLD:  if (w_take) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum1      <= '0;
      r_sum2      <= '0;
      r_count     <= '0;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_end) begin
      r_sum1      <= w_acc1_nxt;
      r_sum2      <= w_acc2_nxt;
      r_count     <= w_cnt_nxt;
      r_ovf       <= {w_ovf2_nxt, w_ovf1_nxt};
      r_out_valid <= 1'b1;
    end else if (w_take) begin
      r_out_valid <= 1'b0;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.sum1      = r_sum1;
  assign io_bus.sum2      = r_sum2;
  assign io_bus.count     = r_count;
  assign io_bus.ovf       = r_ovf;
  assign io_bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_dsp19x2_dual_accumulator.sv
// Self-checking bench for dsp19x2_dual_accumulator.
// Table frames via scoreboard plus hand sequences.
module tb_dsp19x2_dual_accumulator;
  import dsp19x2_pkg::*;

  localparam int LEN = 4;
  localparam int AW  = 24;
  localparam int AW2 = 20;
  localparam int CW  = 3;

  typedef struct {
    longint s1;
    longint s2;
    longint cnt;
    longint ovf;
  } exp_t;

  typedef struct {
    logic [18:0] z1;
    logic [18:0] z2;
    int          n;
    bit          fl;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dsp19x2_dual_accumulator_if #(.ACC_W(AW), .CNT_W(CW)) bus ();
  dsp19x2_dual_accumulator_if #(.ACC_W(AW2), .CNT_W(CW)) bus2 ();

  dsp19x2_dual_accumulator #(
    .LEN(LEN), .ACC_W(AW), .CNT_W(CW)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  dsp19x2_dual_accumulator #(
    .LEN(LEN), .ACC_W(AW2), .CNT_W(CW)
  ) dut2 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus2)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  vec_t vec[7];

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sb_sum1", longint'(bus.sum1), e.s1);
        chk("sb_sum2", longint'(bus.sum2), e.s2);
        chk("sb_count", longint'(bus.count), e.cnt);
        chk("sb_ovf", longint'(bus.ovf), e.ovf);
      end
    end
  end

  task automatic beat(input logic [18:0] a,
                      input logic [18:0] b,
                      input bit fl);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.z1       = a;
    bus.z2       = b;
    bus.flush    = fl;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic frame(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      if (i == v.n - 1) q.push_back(v.e);
      beat(v.z1, v.z2, v.fl && (i == v.n - 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    longint ov_exp;
`ifdef DSP19X2_ACC_SAT_EN
    ov_exp = 1048575;
`else
    ov_exp = 1048572;
`endif
    vec[0] = '{100, 200, 4, 0, '{400, 800, 4, 0}};
    vec[1] = '{522753, 522753, 4, 0,
               '{2091012, 2091012, 4, 0}};
    vec[2] = '{10, 1, 3, 1, '{30, 3, 3, 0}};
    vec[3] = '{0, 0, 4, 0, '{0, 0, 4, 0}};
    vec[4] = '{1, 524287, 1, 1, '{1, 524287, 1, 0}};
    vec[5] = '{3, 5, 2, 1, '{6, 10, 2, 0}};
    vec[6] = '{11, 13, 4, 1, '{44, 52, 4, 0}};

    rst = 1'b1;
    bus.z1 = '0; bus.z2 = '0; bus.in_valid = 1'b0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus2.z1 = '0; bus2.z2 = '0; bus2.in_valid = 1'b0;
    bus2.flush = 1'b0; bus2.out_ready = 1'b0;

    #12;
    chk("rst_sum1", bus.sum1, 0);
    chk("rst_sum2", bus.sum2, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      frame(vec[i]);
      drain();
    end

    // Flush with empty frame must not emit anything.
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_flush_ov", bus.out_valid, 0);
    end
    @(posedge clk); #1;

    // Backpressure with a flush during HOLD.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q.push_back('{28, 36, 4, 0});
      beat(7, 9, 1'b0);
    end
    chk("lat_out_valid", bus.out_valid, 1);
    chk("hold_in_ready", bus.in_ready, 0);
    bus.flush = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_sum1", bus.sum1, 28);
      chk("bp_count", bus.count, 4);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_out_valid", bus.out_valid, 0);
    chk("rel_q_empty", q.size(), 0);
    frame('{1, 1, 4, 0, '{4, 4, 4, 0}});
    drain();

    // Lane overflow on the narrow instance.
    for (int i = 0; i < 4; i++) begin
      bus2.in_valid = 1'b1;
      bus2.z1 = 19'd524287;
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    chk("ovf_out_valid", bus2.out_valid, 1);
    chk("ovf_sum1", bus2.sum1, ov_exp);
    chk("ovf_sum2", bus2.sum2, 0);
    chk("ovf_count", bus2.count, 4);
    chk("ovf_flags", bus2.ovf, 1);
    bus2.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ovf_release", bus2.out_valid, 0);

    // Reset in the middle of a frame.
    beat(9, 9, 1'b0);
    beat(9, 9, 1'b0);
    rst = 1'b1;
    #1;
    chk("mrst_sum1", bus.sum1, 0);
    chk("mrst_count", bus.count, 0);
    chk("mrst_out_valid", bus.out_valid, 0);
    chk("mrst_in_ready", bus.in_ready, 1);
    chk("mrst_sum1_b", bus2.sum1, 0);
    chk("mrst_ovf_b", bus2.ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    frame('{5, 0, 4, 0, '{20, 0, 4, 0}});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
